// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares the single LC-3 memory port between the CPU datapath
// (MIO_EN, R.W, MAR, MDR) and one auxiliary requester. It serves one access at a
// time with fixed memory latency and generates the microsequencer Ready bit.
// Optional feature: define LC3_MEM_ARB_RR_EN for round-robin tie-breaking;
// left undefined, the CPU always wins a tie.
module lc3_mem_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MEM_LATENCY = 1   // 1..4
) (
  input  logic              i_CLK,
  input  logic              i_Reset,
  // CPU side
  input  logic              i_MIO_EN,
  input  logic              i_R_W,
  input  logic [ADDR_W-1:0] i_MAR,
  input  logic [DATA_W-1:0] i_MDR,
  output logic              o_Ready_Bit,
  output logic [DATA_W-1:0] o_CPU_RData,
  // Auxiliary requester
  input  logic              i_Aux_Req,
  input  logic              i_Aux_WE,
  input  logic [ADDR_W-1:0] i_Aux_Addr,
  input  logic [DATA_W-1:0] i_Aux_WData,
  output logic              o_Aux_Gnt,
  output logic              o_Aux_Valid,
  output logic [DATA_W-1:0] o_Aux_RData,
  // Memory side
  output logic              o_Mem_En,
  output logic              o_Mem_WE,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [DATA_W-1:0] o_Mem_WData,
  input  logic [DATA_W-1:0] i_Mem_RData
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam int unsigned    CntW    = 2;
  localparam logic [CntW-1:0] CntInit = CntW'(MEM_LATENCY - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            mio_q;
  logic            cpu_pend_q, cpu_pend_d;
  logic            owner_aux_q;

  logic cpu_edge;
  logic cpu_req;
  logic aux_wins;
  logic cpu_take;

  // A pending edge is only honoured while MIO_EN is still asserted; a level held
  // after completion has mio_q = 1 and no pending flag, so it never re-issues.
  assign cpu_edge = i_MIO_EN & ~mio_q;
  assign cpu_req  = i_MIO_EN & (cpu_pend_q | ~mio_q);

`ifdef LC3_MEM_ARB_RR_EN
  logic last_aux_q;
  // On a tie, the port goes to whichever requester did not own the previous access.
  assign aux_wins = i_Aux_Req & (~cpu_req | ~last_aux_q);
`else
  assign aux_wins = i_Aux_Req & ~cpu_req;
`endif

  assign cpu_take = (state_q == StIdle) & cpu_req & ~aux_wins;

  // Remember an unserved MIO_EN edge until it is accepted or MIO_EN is withdrawn.
  always_comb begin
    cpu_pend_d = cpu_pend_q;
    if (!i_MIO_EN) begin
      cpu_pend_d = 1'b0;
    end else if (cpu_take) begin
      cpu_pend_d = 1'b0;
    end else if (cpu_edge) begin
      cpu_pend_d = 1'b1;
    end
  end

  // Access sequencer with registered outputs: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
  always_ff @(posedge i_CLK) begin
    if (i_Reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mio_q       <= 1'b0;
      cpu_pend_q  <= 1'b0;
      owner_aux_q <= 1'b0;
`ifdef LC3_MEM_ARB_RR_EN
      last_aux_q  <= 1'b1;
`endif
      o_Ready_Bit <= 1'b0;
      o_Aux_Gnt   <= 1'b0;
      o_Aux_Valid <= 1'b0;
      o_Mem_En    <= 1'b0;
      o_Mem_WE    <= 1'b0;
      o_Mem_Addr  <= '0;
      o_Mem_WData <= '0;
      o_CPU_RData <= '0;
      o_Aux_RData <= '0;
    end else begin
      mio_q       <= i_MIO_EN;
      cpu_pend_q  <= cpu_pend_d;
      // Pulse outputs default low; the state that owns them raises them for one cycle.
      o_Ready_Bit <= 1'b0;
      o_Aux_Gnt   <= 1'b0;
      o_Aux_Valid <= 1'b0;
      o_Mem_En    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cpu_req || i_Aux_Req) begin
            owner_aux_q <= aux_wins;
            o_Mem_Addr  <= aux_wins ? i_Aux_Addr  : i_MAR;
            o_Mem_WData <= aux_wins ? i_Aux_WData : i_MDR;
            o_Mem_WE    <= aux_wins ? i_Aux_WE    : i_R_W;
            o_Mem_En    <= 1'b1;
            o_Aux_Gnt   <= aux_wins;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          cnt_q      <= CntInit;
`ifdef LC3_MEM_ARB_RR_EN
          last_aux_q <= owner_aux_q;
`endif
          state_q    <= StWait;
        end
        StWait: begin
          if (cnt_q == '0) begin
            if (!o_Mem_WE) begin
              if (owner_aux_q) begin
                o_Aux_RData <= i_Mem_RData;
              end else begin
                o_CPU_RData <= i_Mem_RData;
              end
            end
            o_Ready_Bit <= ~owner_aux_q;
            o_Aux_Valid <= owner_aux_q;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
